// File: rtl/hypix_readout_pkg.sv
// rtl/hypix_readout_pkg.sv - shared constants and tagged word type for the column readout
package hypix_readout_pkg;

  localparam int DATA_W     = 26;
  localparam int COL_ADDR_W = 6;
  localparam int EOC_W      = COL_ADDR_W + DATA_W;

  // arbiter_data field positions
  localparam int TOA_MSB  = 25;
  localparam int TOA_LSB  = 17;
  localparam int FTOA_MSB = 16;
  localparam int FTOA_LSB = 12;
  localparam int TOT_MSB  = 11;
  localparam int TOT_LSB  = 4;
  localparam int PIX_MSB  = 3;
  localparam int PIX_LSB  = 0;

  typedef struct packed {
    logic [COL_ADDR_W-1:0] col_addr;
    logic [DATA_W-1:0]     data;
  } eoc_word_t;

endpackage

// File: rtl/eoc_sync_fifo.sv
// rtl/eoc_sync_fifo.sv - single-clock show-ahead FIFO with level count
module eoc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // head entry comes straight from storage flops, so it is stable until popped
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/eoc_column_readout.sv
// rtl/eoc_column_readout.sv - end-of-column capture, column tagging, buffering and stall statistic
module eoc_column_readout #(
  parameter int DATA_W     = hypix_readout_pkg::DATA_W,
  parameter int COL_ADDR_W = hypix_readout_pkg::COL_ADDR_W,
  parameter int FIFO_DEPTH = 8,
  parameter int STALL_W    = 8
) (
  input  logic                           clk_40MHz,
  input  logic                           rst_n,
  input  logic [COL_ADDR_W-1:0]          col_addr,
  input  logic [DATA_W-1:0]              arbiter_data,
  input  logic                           shake_hands_last,
  output logic                           shake_hands_next,
  output logic [COL_ADDR_W+DATA_W-1:0]   eoc_data,
  output logic                           eoc_valid,
  input  logic                           eoc_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [STALL_W-1:0]             stall_cnt,
  input  logic                           clear_stats
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [LW-1:0] level_next;

  assign push       = shake_hands_last & shake_hands_next & ~full;
  assign pop        = eoc_valid & eoc_ready;
  assign eoc_valid  = ~empty;
  assign level_next = fifo_level + LW'(push) - LW'(pop);

  eoc_sync_fifo #(
    .WIDTH (COL_ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_40MHz),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({col_addr, arbiter_data}),
    .rdata (eoc_data),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // ready looks one edge ahead at the level, keeping eoc_ready off the ready path
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) shake_hands_next <= 1'b0;
    else        shake_hands_next <= (level_next < LW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n)                                       stall_cnt <= '0;
    else if (clear_stats)                             stall_cnt <= '0;
    else if (shake_hands_last && !shake_hands_next &&
             stall_cnt != {STALL_W{1'b1}})            stall_cnt <= stall_cnt + STALL_W'(1);
  end

endmodule

// File: tb/tb_eoc_column_readout.sv
// tb/tb_eoc_column_readout.sv - randomized self-checking bench with queue reference model
`timescale 1ns/1ps
module tb_eoc_column_readout;
  import hypix_readout_pkg::*;

  logic                  clk_40MHz = 1'b0;
  logic                  rst_n;
  logic [COL_ADDR_W-1:0] col_addr;
  logic [DATA_W-1:0]     arbiter_data;
  logic                  shake_hands_last;
  logic                  shake_hands_next;
  logic [EOC_W-1:0]      eoc_data;
  logic                  eoc_valid;
  logic                  eoc_ready;
  logic [3:0]            fifo_level;
  logic [7:0]            stall_cnt;
  logic                  clear_stats;

  eoc_column_readout dut (
    .clk_40MHz        (clk_40MHz),
    .rst_n            (rst_n),
    .col_addr         (col_addr),
    .arbiter_data     (arbiter_data),
    .shake_hands_last (shake_hands_last),
    .shake_hands_next (shake_hands_next),
    .eoc_data         (eoc_data),
    .eoc_valid        (eoc_valid),
    .eoc_ready        (eoc_ready),
    .fifo_level       (fifo_level),
    .stall_cnt        (stall_cnt),
    .clear_stats      (clear_stats)
  );

  always #12.5 clk_40MHz = ~clk_40MHz;

  int checks = 0;
  int errors = 0;

  // reference model: buffered words, words the chain still has to deliver, ready, stall count
  eoc_word_t         q[$];
  logic [DATA_W-1:0] src[$];
  bit                m_ready = 1'b0;
  int                m_stall = 0;
  int                rdy_pct = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    shake_hands_last = (src.size() != 0);
    arbiter_data     = shake_hands_last ? src[0] : DATA_W'($urandom);
    eoc_ready        = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic step();
    bit        do_push;
    bit        do_pop;
    bit        stalled;
    eoc_word_t w;
    do_push = shake_hands_last && m_ready;
    do_pop  = eoc_ready && (q.size() != 0);
    stalled = shake_hands_last && !m_ready;
    w       = {col_addr, arbiter_data};
    @(posedge clk_40MHz);
    if (clear_stats)                 m_stall = 0;
    else if (stalled && m_stall < 255) m_stall++;
    if (do_pop)  void'(q.pop_front());
    if (do_push) begin
      q.push_back(w);
      void'(src.pop_front());
    end
    m_ready = (q.size() < 8);
    @(negedge clk_40MHz);
    chk("ready", 64'(shake_hands_next), 64'(m_ready));
    chk("valid", 64'(eoc_valid), 64'(q.size() != 0));
    chk("level", 64'(fifo_level), 64'(q.size()));
    chk("stall", 64'(stall_cnt), 64'(m_stall));
    if (q.size() != 0) chk("data", 64'(eoc_data), 64'(q[0]));
    drive();
  endtask

  task automatic model_reset();
    q.delete();
    src.delete();
    m_ready = 1'b0;
    m_stall = 0;
  endtask

  initial begin
    logic [EOC_W-1:0] single_exp;
    rst_n            = 1'b0;
    col_addr         = '0;
    arbiter_data     = '0;
    shake_hands_last = 1'b0;
    eoc_ready        = 1'b0;
    clear_stats      = 1'b0;

    // reset then idle
    #20;
    chk("rst_ready", 64'(shake_hands_next), 64'd0);
    chk("rst_valid", 64'(eoc_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_data",  64'(eoc_data), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    #5 rst_n = 1'b1;
    step();
    chk("ready_after_reset", 64'(shake_hands_next), 64'd1);
    step();

    // single tagged word
    col_addr   = 6'd5;
    single_exp = {6'd5, 26'h34A5A71};
    src.push_back(26'h34A5A71);
    rdy_pct = 100;
    drive();
    step();
    chk("single_valid", 64'(eoc_valid), 64'd1);
    chk("single_data",  64'(eoc_data), 64'(single_exp));
    step();
    chk("single_level", 64'(fifo_level), 64'd0);

    // fill with backpressure, then drain in order
    col_addr = 6'($urandom);
    rdy_pct  = 0;
    for (int i = 1; i <= 10; i++) src.push_back(DATA_W'(i));
    drive();
    for (int i = 0; i < 12; i++) step();
    chk("fill_level", 64'(fifo_level), 64'd8);
    chk("fill_ready", 64'(shake_hands_next), 64'd0);
    chk("fill_stall", 64'(stall_cnt), 64'd4);
    rdy_pct = 100;
    drive();
    for (int i = 0; i < 14; i++) step();
    chk("drain_level", 64'(fifo_level), 64'd0);

    // include an all-zero word, then hold level 7 with simultaneous push/pop
    col_addr = 6'($urandom);
    rdy_pct  = 0;
    src.push_back('0);
    for (int i = 0; i < 6; i++) src.push_back(DATA_W'($urandom));
    drive();
    for (int i = 0; i < 7; i++) step();
    chk("lvl7_level", 64'(fifo_level), 64'd7);
    for (int i = 0; i < 20; i++) src.push_back(DATA_W'($urandom));
    rdy_pct = 100;
    drive();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("pp_level", 64'(fifo_level), 64'd7);
      chk("pp_ready", 64'(shake_hands_next), 64'd1);
    end

    // stall counter saturation and clear
    rdy_pct = 0;
    for (int i = 0; i < 20; i++) src.push_back(DATA_W'($urandom));
    drive();
    for (int i = 0; i < 300; i++) step();
    chk("stall_sat", 64'(stall_cnt), 64'd255);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("stall_clear", 64'(stall_cnt), 64'd0);
    rdy_pct = 100;
    drive();
    for (int i = 0; i < 40; i++) step();
    chk("drain2_level", 64'(fifo_level), 64'd0);

    // asynchronous reset with words buffered
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) src.push_back(DATA_W'($urandom));
    drive();
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_level", 64'(fifo_level), 64'd5);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(eoc_valid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_ready", 64'(shake_hands_next), 64'd0);
    chk("mid_rst_data",  64'(eoc_data), 64'd0);
    model_reset();
    drive();
    @(negedge clk_40MHz);
    rst_n = 1'b1;

    // randomized traffic after reset; none of the discarded words may surface
    col_addr = 6'($urandom);
    rdy_pct  = 60;
    for (int i = 0; i < 30; i++) src.push_back(DATA_W'($urandom));
    drive();
    for (int i = 0; i < 80; i++) step();
    rdy_pct = 100;
    drive();
    for (int i = 0; i < 40; i++) step();
    chk("final_level", 64'(fifo_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
